// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   fq_entry_t  : one buffered instruction with its byte PC
//   fq_state_e  : fetch control states
//   INSTR_BYTES : byte stride between sequential fetches
//   align_word  : clears the byte-offset bits of a byte address
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fq_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer holding fetched instructions and their PCs.
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   flush_i               : empties the buffer; overrides push and pop
//   push_i, push_instr_i,
//   push_pc_i             : write one entry at the tail
//   pop_i                 : retire the head entry (ignored when empty)
//   head_valid_o          : buffer is non-empty
//   head_instr_o,
//   head_pc_o             : head entry, forced to zero when empty
//   count_o               : number of entries held
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [31:0]      push_instr_i,
  input  logic [31:0]      push_pc_i,
  input  logic             pop_i,
  output logic             head_valid_o,
  output logic [31:0]      head_instr_o,
  output logic [31:0]      head_pc_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fq_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic             empty_s;

  // Qualify push/pop: flush wins, pop needs data, push needs room (or a pop).
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    do_pop_s  = pop_i && !flush_i && !empty_s;
    do_push_s = push_i && !flush_i && ((count_r != CNT_FULL) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, head is masked.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= '{instr: push_instr_i, pc: push_pc_i};
    end
  end

  // Head presentation, zeroed when empty so reset leaves outputs at zero.
  always_comb begin
    head_valid_o = !empty_s;
    count_o      = count_r;
    if (!empty_s) begin
      head_instr_o = mem_r[rd_ptr_r].instr;
      head_pc_o    = mem_r[rd_ptr_r].pc;
    end else begin
      head_instr_o = 32'h0000_0000;
      head_pc_o    = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage between instruction memory and decode.
// Issues sequential word fetches, buffers responses with their PCs and
// hands them to decode over valid/ready. A redirect flushes the queue,
// drops any response still in flight and restarts at the target.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   imem_req_o, imem_addr_o        : fetch request and word address
//   imem_rvalid_i, imem_rdata_i    : response, one cycle after the request
//   redirect_i, redirect_pc_i      : branch/jump flush and target byte PC
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_ready_i      : decode handshake on the queue head
//   count_o                        : entries currently buffered
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 20,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  input  logic              instr_ready_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [31:0]  PC_STEP = 32'(INSTR_BYTES);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fq_state_e   state_r;
  fq_state_e   state_next_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] req_pc_r;
  logic        inflight_r;
  logic        discard_r;
  logic        req_s;
  logic        pop_s;
  logic        push_s;
  logic [CNT_W:0] occ_s;

  // Handshake, projected occupancy and request decision.
  // The in-flight response will land before any new request returns, so it
  // is counted against capacity; that makes overflow impossible.
  always_comb begin
    pop_s  = instr_valid_o && instr_ready_i;
    push_s = imem_rvalid_i && !discard_r;
    occ_s  = {1'b0, count_o} - {{CNT_W{1'b0}}, pop_s} + {{CNT_W{1'b0}}, inflight_r};
    if (!reset_i && (state_r == FETCH) && (occ_s < DEPTH_C)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Next-state logic. A request issued in the redirect cycle returns stale
  // data, so DRAIN waits for it. The stale response always arrives in the
  // first DRAIN cycle; leaving on it even under a second redirect avoids
  // waiting forever for a response that will never come.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        state_next_s = FETCH;
      end
      FETCH: begin
        if (redirect_i && req_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) begin
          state_next_s = FETCH;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Control state, fetch PC, in-flight tracking and discard flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
      inflight_r <= 1'b0;
      discard_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      inflight_r <= req_s;
      if (req_s) begin
        req_pc_r <= fetch_pc_r;
      end
      if (redirect_i) begin
        fetch_pc_r <= align_word(redirect_pc_i);
      end else if (req_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (redirect_i && req_s) begin
        discard_r <= 1'b1;
      end else if (discard_r && imem_rvalid_i) begin
        discard_r <= 1'b0;
      end
    end
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_r[ADDR_W+1:2];

  // Redirect flushes the buffer, which also drops a same-cycle push or pop.
  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (redirect_i),
    .push_i       (push_s),
    .push_instr_i (imem_rdata_i),
    .push_pc_i    (req_pc_r),
    .pop_i        (pop_s),
    .head_valid_o (instr_valid_o),
    .head_instr_o (instr_o),
    .head_pc_o    (instr_pc_o),
    .count_o      (count_o)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. A one-cycle-latency memory model returns
// word = word_address * 4 for every request captured before the clock edge.
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_rvalid_i;
  logic [31:0]       imem_rdata_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [31:0]       instr_pc_o;
  logic              instr_ready_i;
  logic [CNT_W-1:0]  count_o;

  int checks   = 0;
  int failures = 0;
  int nreq;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory model answers the request seen before the edge.
  task automatic step();
    logic              r;
    logic [ADDR_W-1:0] a;
    r = imem_req_o;
    a = imem_addr_o;
    @(posedge clk_i);
    #1;
    imem_rvalid_i = r;
    imem_rdata_i  = {10'b0, a, 2'b00};
    #1;
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  // Leaves the bench in the IDLE cycle right after reset deasserts.
  task automatic do_reset(input logic rdy);
    reset_i = 1'b1;
    drive(rdy, 1'b0, 32'h0);
    step();
    step();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset_i       = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;

    // Streaming from reset with decode always ready.
    do_reset(1'b1);
    check_eq("rst_req",   64'(imem_req_o), 64'h0);
    check_eq("rst_valid", 64'(instr_valid_o), 64'h0);
    check_eq("rst_instr", 64'(instr_o), 64'h0);
    check_eq("rst_pc",    64'(instr_pc_o), 64'h0);
    check_eq("rst_count", 64'(count_o), 64'h0);
    step();
    check_eq("s_req1",   64'(imem_req_o), 64'h1);
    check_eq("s_addr0",  64'(imem_addr_o), 64'h0);
    step();
    check_eq("s_nobyp",  64'(instr_valid_o), 64'h0);
    check_eq("s_addr1",  64'(imem_addr_o), 64'h1);
    step();
    check_eq("s_valid0", 64'(instr_valid_o), 64'h1);
    check_eq("s_pc0",    64'(instr_pc_o), 64'h0);
    check_eq("s_ins0",   64'(instr_o), 64'h0);
    step();
    check_eq("s_pc4",    64'(instr_pc_o), 64'h4);
    check_eq("s_ins4",   64'(instr_o), 64'h4);
    step();
    check_eq("s_pc8",    64'(instr_pc_o), 64'h8);
    check_eq("s_cnt1",   64'(count_o), 64'h1);

    // Backpressure: queue fills to DEPTH and requests stop.
    do_reset(1'b0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      nreq += int'(imem_req_o);
      step();
    end
    check_eq("bp_nreq",  64'(nreq), 64'h4);
    check_eq("bp_count", 64'(count_o), 64'h4);
    check_eq("bp_req0",  64'(imem_req_o), 64'h0);
    check_eq("bp_head",  64'(instr_pc_o), 64'h0);
    drive(1'b1, 1'b0, 32'h0);
    check_eq("bp_resume_addr", 64'(imem_addr_o), 64'h4);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_pop_valid", 64'(instr_valid_o), 64'h1);
      check_eq("bp_pop_pc",    64'(instr_pc_o), 64'(i * 4));
      check_eq("bp_pop_req",   64'(imem_req_o), 64'h1);
      step();
    end

    // Redirect while a request is in flight.
    drive(1'b1, 1'b1, 32'h0000_0102);
    check_eq("rd_req_in_redir", 64'(imem_req_o), 64'h1);
    step();
    drive(1'b1, 1'b0, 32'h0);
    check_eq("rd_drain_valid", 64'(instr_valid_o), 64'h0);
    check_eq("rd_drain_count", 64'(count_o), 64'h0);
    check_eq("rd_drain_req",   64'(imem_req_o), 64'h0);
    step();
    check_eq("rd_req",   64'(imem_req_o), 64'h1);
    check_eq("rd_addr",  64'(imem_addr_o), 64'h40);
    check_eq("rd_v1",    64'(instr_valid_o), 64'h0);
    step();
    check_eq("rd_v2",    64'(instr_valid_o), 64'h0);
    check_eq("rd_addr2", 64'(imem_addr_o), 64'h41);
    step();
    check_eq("rd_valid", 64'(instr_valid_o), 64'h1);
    check_eq("rd_pc",    64'(instr_pc_o), 64'h100);
    check_eq("rd_instr", 64'(instr_o), 64'h100);

    // Redirect together with a pop at count 3.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    check_eq("rp_count3", 64'(count_o), 64'h3);
    drive(1'b1, 1'b1, 32'h0000_0200);
    check_eq("rp_req", 64'(imem_req_o), 64'h1);
    step();
    drive(1'b1, 1'b0, 32'h0);
    check_eq("rp_count0", 64'(count_o), 64'h0);
    check_eq("rp_valid0", 64'(instr_valid_o), 64'h0);
    step();
    check_eq("rp_addr", 64'(imem_addr_o), 64'h80);
    step();
    check_eq("rp_valid_gap", 64'(instr_valid_o), 64'h0);
    step();
    check_eq("rp_valid", 64'(instr_valid_o), 64'h1);
    check_eq("rp_pc",    64'(instr_pc_o), 64'h200);

    // Reset mid-stream with entries buffered and a response on its way.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    check_eq("mr_count2", 64'(count_o), 64'h2);
    reset_i = 1'b1;
    #1;
    check_eq("mr_req_gated", 64'(imem_req_o), 64'h0);
    step();
    reset_i = 1'b0;
    #1;
    check_eq("mr_req",   64'(imem_req_o), 64'h0);
    check_eq("mr_valid", 64'(instr_valid_o), 64'h0);
    check_eq("mr_instr", 64'(instr_o), 64'h0);
    check_eq("mr_pc",    64'(instr_pc_o), 64'h0);
    check_eq("mr_count", 64'(count_o), 64'h0);
    step();
    check_eq("mr_no_late_push", 64'(count_o), 64'h0);
    check_eq("mr_fetch_req",    64'(imem_req_o), 64'h1);
    check_eq("mr_fetch_addr",   64'(imem_addr_o), 64'h0);

    // PC wrap at the top of the address space.
    do_reset(1'b1);
    drive(1'b1, 1'b1, 32'hFFFF_FFFE);
    check_eq("wr_req_idle", 64'(imem_req_o), 64'h0);
    step();
    drive(1'b1, 1'b0, 32'h0);
    check_eq("wr_req",   64'(imem_req_o), 64'h1);
    check_eq("wr_addr_top", 64'(imem_addr_o), 64'hFFFFF);
    step();
    check_eq("wr_addr_zero", 64'(imem_addr_o), 64'h0);
    step();
    check_eq("wr_pc_top",    64'(instr_pc_o), 64'hFFFF_FFFC);
    check_eq("wr_instr_top", 64'(instr_o), 64'h003F_FFFC);
    step();
    check_eq("wr_pc_zero",   64'(instr_pc_o), 64'h0);
    check_eq("wr_valid",     64'(instr_valid_o), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
